// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants and state type for the 8-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] DEC_XOR = 3'b100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter_8_decoder_3to8.sv
// ============================================================================
// Module      : decoder_3to8
// Description : 3-to-8 decoder; output k is asserted when sel_i == k ^ DEC_XOR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_3to8
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] sel_i,
  output logic [N_REQ-1:0] dec_o
);

  for (genvar k = 0; k < N_REQ; k++) begin : g_dec
    assign dec_o[k] = (sel_i == (IDX_W'(k) ^ DEC_XOR));
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
// ============================================================================
// Module      : rr_arbiter_8
// Description : Round-robin arbiter, 8 requesters, grant held until done,
//               withdrawal or hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] request_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             timeout_o
);

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              timeout_hit;
  logic              holder_left;
  logic [IDX_W:0]    pick_idle, pick_rel;
  logic [N_REQ-1:0]  dec;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic               found;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return {found, IDX_W'(off + ptr)};
  endfunction

  if (MAX_HOLD == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end else begin : g_timeout
    assign timeout_hit = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
  end

  assign holder_left = done_i | ~request_i[idx_q];
  assign pick_idle   = pick(request_i, ptr_q);
  assign pick_rel    = pick(request_i, IDX_W'(idx_q + 1'b1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle[IDX_W]) begin
          state_d    = GRANT;
          idx_d      = pick_idle[IDX_W-1:0];
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (holder_left | timeout_hit) begin
          ptr_d     = IDX_W'(idx_q + 1'b1);
          timeout_d = timeout_hit & ~holder_left;
          if (pick_rel[IDX_W]) begin
            idx_d      = pick_rel[IDX_W-1:0];
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != {HC_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decoder input is pre-XORed so that its output lines up with grant_idx_o.
  decoder_3to8 u_dec (
    .sel_i (idx_q ^ DEC_XOR),
    .dec_o (dec)
  );

  assign grant_valid_o = (state_q == GRANT);
  assign grant_idx_o   = idx_q;
  assign timeout_o     = timeout_q;
  assign grant_o       = grant_valid_o ? dec : '0;

endmodule

`default_nettype wire
